// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and helpers for the keypad scanner
package keypad_pkg;

  localparam logic EVT_RELEASE = 1'b0;
  localparam logic EVT_PRESS   = 1'b1;

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - synchronous FIFO with registered storage and occupancy count
module keypad_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_events.sv
// rtl/keypad_scan_events.sv - matrix keypad scanner with per-key debounce and press/release event queue
module keypad_scan_events
  import keypad_pkg::*;
#(
  parameter int ROWS             = 4,
  parameter int COLS             = 4,
  parameter int SCAN_CYCLES      = 500,
  parameter int SAMPLE_DELAY     = 2,
  parameter int DEBOUNCE_SAMPLES = 6,
  parameter int FIFO_DEPTH       = 8,
  localparam int KEY_W = key_width(ROWS, COLS),
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [COLS-1:0]      cols_in,
  output logic [ROWS-1:0]      rows_out,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  output logic                 evt_press,
  output logic [KEY_W-1:0]     evt_code,
  input  logic                 evt_ready,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int NKEYS  = ROWS * COLS;
  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_SAMPLES + 1);

  typedef struct packed {
    logic             press;
    logic [KEY_W-1:0] code;
  } key_evt_t;

  logic [SCAN_W-1:0] scan_cnt;
  logic [ROW_W-1:0]  row_idx;
  logic [COLS-1:0]   col_meta;
  logic [COLS-1:0]   col_sync;
  logic [DB_W-1:0]   db_cnt [NKEYS];
  logic [DB_W-1:0]   db_nxt [NKEYS];
  logic [NKEYS-1:0]  ks_nxt;
  logic [COLS-1:0]   flips;
  logic [COLS-1:0]   pending;
  logic [COLS-1:0]   pending_nxt;
  logic              sample_edge;
  logic              scan_wrap;
  logic [KEY_W-1:0]  k;
  logic [COL_W-1:0]  emit_col;
  logic              emit_valid;
  logic [KEY_W-1:0]  emit_code;
  key_evt_t          evt_in;
  key_evt_t          evt_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  assign rows_out    = enable ? ~(ROWS'(1) << row_idx) : '1;
  assign sample_edge = enable && (scan_cnt == SCAN_W'(SAMPLE_DELAY));
  assign scan_wrap   = (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));

  // Debounce every column of the active row; a key flips only after a full run of disagreeing samples.
  always_comb begin
    ks_nxt = key_state;
    db_nxt = db_cnt;
    flips  = '0;
    k      = '0;
    for (int c = 0; c < COLS; c++) begin
      k = KEY_W'(int'(row_idx) * COLS + c);
      if (~col_sync[c] == key_state[k]) begin
        db_nxt[k] = '0;
      end else if (db_cnt[k] == DB_W'(DEBOUNCE_SAMPLES - 1)) begin
        ks_nxt[k] = ~key_state[k];
        db_nxt[k] = '0;
        flips[c]  = 1'b1;
      end else begin
        db_nxt[k] = db_cnt[k] + 1'b1;
      end
    end
  end

  // Serialise flipped columns lowest first; downward scan leaves the lowest set bit in emit_col.
  always_comb begin
    emit_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pending[c]) emit_col = COL_W'(c);
    end
    emit_valid  = |pending;
    pending_nxt = pending & (pending - 1'b1);
    if (sample_edge) pending_nxt = pending_nxt | flips;
  end

  assign emit_code    = KEY_W'(int'(row_idx) * COLS + int'(emit_col));
  assign evt_in.code  = emit_code;
  assign evt_in.press = key_state[emit_code] ? EVT_PRESS : EVT_RELEASE;
  assign drop         = emit_valid && fifo_full && !evt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      row_idx  <= '0;
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= cols_in;
      col_sync <= col_meta;
      if (enable) begin
        if (scan_wrap) begin
          scan_cnt <= '0;
          row_idx  <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
    end else begin
      if (sample_edge) begin
        key_state <= ks_nxt;
        db_cnt    <= db_nxt;
      end
      pending <= pending_nxt;
      if (drop) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  keypad_event_fifo #(
    .WIDTH($bits(key_evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (emit_valid),
    .push_data(evt_in),
    .pop      (evt_ready),
    .pop_data (evt_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign evt_valid = !fifo_empty;
  assign evt_press = evt_head.press;
  assign evt_code  = evt_head.code;

endmodule

// File: tb/tb_keypad_scan_events.sv
// tb/tb_keypad_scan_events.sv - self-checking bench with a physical keypad and event-level reference model
module tb_keypad_scan_events;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN = 16;
  localparam int DLY  = 2;
  localparam int DB   = 3;
  localparam int DEP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  cols_in;
  logic [3:0]  rows_out;
  logic [15:0] key_state;
  logic        evt_valid;
  logic        evt_press;
  logic [3:0]  evt_code;
  logic        evt_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;

  always #5 clk = ~clk;

  keypad_scan_events #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SCAN), .SAMPLE_DELAY(DLY),
    .DEBOUNCE_SAMPLES(DB), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cols_in(cols_in), .rows_out(rows_out),
    .key_state(key_state), .evt_valid(evt_valid), .evt_press(evt_press), .evt_code(evt_code),
    .evt_ready(evt_ready), .fifo_level(fifo_level), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  typedef struct { bit press; int code; } evt_t;

  bit   pressed [16];
  int   m_ecount;
  bit   m_ks [16];
  int   m_cnt [16];
  evt_t m_pend[$];
  evt_t m_fifo[$];
  bit   m_ov;
  evt_t log_q[$];
  bit   check_en;
  int   checks = 0;
  int   errors = 0;

  function automatic int m_row();
    return (m_ecount / SCAN) % ROWS;
  endfunction

  function automatic int m_pos();
    return m_ecount % SCAN;
  endfunction

  function automatic logic [15:0] m_ks_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_ks[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_ecount = 0;
    for (int i = 0; i < 16; i++) begin
      m_ks[i]  = 1'b0;
      m_cnt[i] = 0;
    end
    m_pend.delete();
    m_fifo.delete();
    m_ov = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the reference: consumer pop, one queued emission, then the row sample.
  function automatic void model_step();
    evt_t ev;
    bit   has_push;
    bit   drop;
    int   k;
    if (rst) begin
      model_reset();
      return;
    end
    has_push = (m_pend.size() > 0);
    if (has_push) ev = m_pend.pop_front();
    if (m_fifo.size() > 0 && evt_ready) void'(m_fifo.pop_front());
    drop = 1'b0;
    if (has_push) begin
      if (m_fifo.size() < DEP) m_fifo.push_back(ev);
      else drop = 1'b1;
    end
    if (drop) m_ov = 1'b1;
    else if (clear_overflow) m_ov = 1'b0;
    if (enable && m_pos() == DLY) begin
      for (int c = 0; c < COLS; c++) begin
        k = m_row() * COLS + c;
        if (pressed[k] == m_ks[k]) m_cnt[k] = 0;
        else if (m_cnt[k] + 1 >= DB) begin
          m_ks[k]  = !m_ks[k];
          m_cnt[k] = 0;
          m_pend.push_back('{m_ks[k], k});
        end else m_cnt[k]++;
      end
    end
    if (enable) m_ecount++;
  endfunction

  task automatic check_outputs();
    logic [3:0] exp_rows;
    if (!check_en) return;
    exp_rows = enable ? ~(4'b0001 << m_row()) : 4'b1111;
    chk("rows_out", rows_out, exp_rows);
    chk("key_state", key_state, m_ks_vec());
    chk("evt_valid", evt_valid, m_fifo.size() != 0);
    chk("fifo_level", fifo_level, m_fifo.size());
    chk("overflow", overflow, m_ov);
    if (m_fifo.size() != 0) begin
      chk("evt_code", evt_code, m_fifo[0].code);
      chk("evt_press", evt_press, m_fifo[0].press);
    end
  endtask

  task automatic cycle();
    logic any;
    #1;
    for (int c = 0; c < COLS; c++) begin
      any = 1'b0;
      for (int r = 0; r < ROWS; r++) if (!rows_out[r] && pressed[r*COLS+c]) any = 1'b1;
      cols_in[c] = ~any;
    end
    check_outputs();
    if (evt_valid && evt_ready) log_q.push_back('{evt_press, int'(evt_code)});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int r, input int p);
    int guard = 0;
    while (!(m_row() == r && m_pos() == p) && guard < 400) begin
      cycle();
      guard++;
    end
    chk("run_to_bound", guard < 400, 1);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cycle();
      run_to(3, 8);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[6];
    pat = '{1, 1, 0, 1, 1, 1};
    rst = 1'b1; enable = 1'b1; evt_ready = 1'b1; clear_overflow = 1'b0; cols_in = '1;
    for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    check_en = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_en = 1'b1;
    cycle();
    rst = 1'b0;
    chk("reset_rows", rows_out, 4'b1110);
    chk("reset_ks", key_state, 16'h0000);
    chk("reset_valid", evt_valid, 1'b0);
    chk("reset_press", evt_press, 1'b0);
    chk("reset_code", evt_code, 4'h0);
    chk("reset_level", fifo_level, 3'd0);
    chk("reset_ovf", overflow, 1'b0);

    // Single key 9: nothing after two samples, press after the third, then release.
    run_to(3, 8);
    pressed[9] = 1'b1;
    log_q.delete();
    frames(2);
    chk("single_two_samples", key_state[9], 1'b0);
    frames(1);
    chk("single_ks", key_state[9], 1'b1);
    chk("single_evt_cnt", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("single_code", log_q[0].code, 9);
      chk("single_press", log_q[0].press, 1'b1);
    end
    pressed[9] = 1'b0;
    log_q.delete();
    frames(3);
    chk("release_ks", key_state[9], 1'b0);
    chk("release_evt_cnt", log_q.size(), 1);
    if (log_q.size() > 0) chk("release_press", log_q[0].press, 1'b0);

    // Bounce on key 9.
    log_q.delete();
    for (int i = 0; i < 6; i++) begin
      pressed[9] = pat[i][0];
      frames(1);
      if (i == 4) chk("bounce_before_6th", key_state[9], 1'b0);
    end
    chk("bounce_evt_cnt", log_q.size(), 1);
    if (log_q.size() > 0) chk("bounce_code", log_q[0].code, 9);
    pressed[9] = 1'b0;
    frames(3);

    // Same-row keys 4 and 7.
    log_q.delete();
    pressed[4] = 1'b1; pressed[7] = 1'b1;
    frames(3);
    chk("multi_ks", key_state & 16'h0090, 16'h0090);
    chk("multi_evt_cnt", log_q.size(), 2);
    if (log_q.size() > 1) begin
      chk("multi_first", log_q[0].code, 4);
      chk("multi_second", log_q[1].code, 7);
    end
    pressed[4] = 1'b0; pressed[7] = 1'b0;
    frames(3);

    // Overflow: five presses into a four-entry queue with no consumer.
    evt_ready = 1'b0;
    log_q.delete();
    for (int i = 0; i < 4; i++) pressed[i] = 1'b1;
    pressed[10] = 1'b1;
    frames(3);
    chk("ovf_level", fifo_level, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_ks", key_state, 16'h040F);
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    evt_ready = 1'b1;
    repeat (4) cycle();
    chk("ovf_pop_cnt", log_q.size(), 4);
    for (int i = 0; i < log_q.size() && i < 4; i++) chk("ovf_order", log_q[i].code, i);
    chk("ovf_drained", fifo_level, 3'd0);
    for (int i = 0; i < 4; i++) pressed[i] = 1'b0;
    pressed[10] = 1'b0;
    frames(3);

    // Freeze mid-row, then resume at the same position.
    run_to(1, 8);
    enable = 1'b0;
    repeat (10) cycle();
    chk("freeze_rows", rows_out, 4'b1111);
    enable = 1'b1;
    #1;
    chk("resume_rows", rows_out, 4'b1101);
    run_to(3, 8);

    // Reset during a partial debounce of key 6.
    pressed[6] = 1'b1;
    frames(2);
    chk("partial_ks", key_state[6], 1'b0);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    log_q.delete();
    frames(2);
    chk("post_reset_two", key_state[6], 1'b0);
    chk("post_reset_no_evt", log_q.size(), 0);
    frames(1);
    chk("post_reset_three", key_state[6], 1'b1);
    chk("post_reset_evt_cnt", log_q.size(), 1);
    if (log_q.size() > 0) chk("post_reset_code", log_q[0].code, 6);

    // Randomised traffic against the model.
    for (int f = 0; f < 40; f++) begin
      int guard;
      for (int i = 0; i < 16; i++) if ($urandom_range(7) == 0) pressed[i] = !pressed[i];
      cycle();
      guard = 0;
      while (!(m_row() == 3 && m_pos() == 8) && guard < 400) begin
        evt_ready = ($urandom_range(2) != 0);
        clear_overflow = ($urandom_range(19) == 0);
        if (enable) begin
          if (m_pos() >= 4 && $urandom_range(39) == 0) enable = 1'b0;
        end else if ($urandom_range(3) == 0) enable = 1'b1;
        cycle();
        guard++;
      end
      chk("rand_frame_bound", guard < 400, 1);
      enable = 1'b1;
      clear_overflow = 1'b0;
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    frames(4);
    chk("final_level", fifo_level, 3'd0);
    chk("final_ks", key_state, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
